// File: rtl/mem_access_unit_if.sv
// Pipeline-side and device-bus signals of the memory-stage access unit.
// master = the access unit, slave = pipeline/device environment.
interface mem_access_unit_if;
  logic        Valid;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  OpWidth;
  logic        LoadSigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [4:0]  ExcCodeIn;
  logic        IntReq;
  logic        Stall;
  logic [31:0] RData;
  logic        RValid;
  logic        ExcValid;
  logic [4:0]  ExcCode;
  logic        PrReq;
  logic [31:0] PrAddr;
  logic        PrWE;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic        PrAck;
  logic [31:0] PrRD;

  modport master (
    input  Valid, MemRead, MemWrite, OpWidth, LoadSigned,
    input  Addr, WData, ExcCodeIn, IntReq, PrAck, PrRD,
    output Stall, RData, RValid, ExcValid, ExcCode,
    output PrReq, PrAddr, PrWE, PrBE, PrWD
  );

  modport slave (
    output Valid, MemRead, MemWrite, OpWidth, LoadSigned,
    output Addr, WData, ExcCodeIn, IntReq, PrAck, PrRD,
    input  Stall, RData, RValid, ExcValid, ExcCode,
    input  PrReq, PrAddr, PrWE, PrBE, PrWD
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: data RAM, device windows, AdEL/AdES/DBE.
// Define MEM_ACCESS_TIMEOUT_EN to raise DBE on unacknowledged device requests.
module mem_access_unit #(
  parameter int unsigned DM_WORDS   = 2048,
  parameter int          NUM_DEV    = 3,
  parameter logic [31:0] DEV_BASE   = 32'h7F00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter logic [31:0] DEV_SIZE   = 32'hC,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic               Clk,
  input logic               Reset,
  mem_access_unit_if.master bus
);
  localparam int unsigned IW = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS) << 2;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DM_RD,
    S_DEV_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [1:0]  r_width;
  logic        r_signed;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_ram_q;
  logic [31:0] r_mem [DM_WORDS];

  logic        w_hit_dm;
  logic        w_hit_dev;
  logic        w_half;
  logic        w_byte;
  logic        w_word;
  logic        w_mem;
  logic        w_misal;
  logic [4:0]  w_acode;
  logic [4:0]  w_exc_code;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_go;
  logic        w_dm_wr;
  logic        w_dm_rd;
  logic        w_dev;
  logic        w_tmo;
  logic [IW-1:0] w_idx;

  function automatic logic [31:0] f_ext(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  wd,
    input logic        sgn
  );
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    b = off[0] ? h[15:8] : h[7:0];
    f_ext = w;
    if (wd == 2'b01)
      f_ext = {{16{sgn & h[15]}}, h};
    else if (wd == 2'b10)
      f_ext = {{24{sgn & b[7]}}, b};
  endfunction

  assign w_hit_dm = bus.Addr < DM_BYTES;
  assign w_idx    = bus.Addr[IW+1:2];

  always_comb begin
    w_hit_dev = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (bus.Addr >= DEV_BASE + 32'(i) * DEV_STRIDE &&
          bus.Addr <= DEV_BASE + 32'(i) * DEV_STRIDE
                      + DEV_SIZE - 32'd1)
        w_hit_dev = 1'b1;
    end
  end

  assign w_half  = bus.OpWidth == 2'b01;
  assign w_byte  = bus.OpWidth == 2'b10;
  assign w_word  = !w_half && !w_byte;
  assign w_mem   = bus.MemRead || bus.MemWrite;
  assign w_acode = bus.MemRead ? EXC_ADEL : EXC_ADES;
  assign w_misal = (w_word && bus.Addr[1:0] != 2'b00)
                || (w_half && bus.Addr[0]);

  // Earlier-stage codes win, then alignment, then window decode.
  always_comb begin
    w_exc_code = 5'd0;
    if (bus.ExcCodeIn != 5'd0)
      w_exc_code = bus.ExcCodeIn;
    else if (w_mem && w_misal)
      w_exc_code = w_acode;
    else if (w_mem && !w_hit_dm && w_hit_dev && !w_word)
      w_exc_code = w_acode;
    else if (w_mem && !w_hit_dm && !w_hit_dev)
      w_exc_code = w_acode;
  end

  always_comb begin
    w_be = 4'b1111;
    w_wd = bus.WData;
    if (w_half) begin
      w_be = bus.Addr[1] ? 4'b1100 : 4'b0011;
      w_wd = {2{bus.WData[15:0]}};
    end else if (w_byte) begin
      w_be = 4'b0001 << bus.Addr[1:0];
      w_wd = {4{bus.WData[7:0]}};
    end
  end

  assign w_go = !Reset && r_state == S_IDLE && bus.Valid
             && w_mem && w_exc_code == 5'd0 && !bus.IntReq;
  assign w_dm_wr = w_go && !bus.MemRead && w_hit_dm;
  assign w_dm_rd = w_go && bus.MemRead && w_hit_dm;
  assign w_dev   = w_go && !w_hit_dm;

  always_ff @(posedge Clk) begin
    if (w_dm_wr) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
    end
    r_ram_q <= r_mem[w_idx];
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  assign w_tmo = r_state == S_DEV_WAIT && !bus.PrAck
              && r_cnt == CW'(TIMEOUT - 1);

  always_ff @(posedge Clk) begin
    if (Reset)
      r_cnt <= '0;
    else if (w_go)
      r_cnt <= '0;
    else if (r_state == S_DEV_WAIT)
      r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wd     <= '0;
      r_width  <= '0;
      r_signed <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_go) begin
        r_addr   <= bus.Addr;
        r_we     <= !bus.MemRead;
        r_be     <= w_be;
        r_wd     <= w_wd;
        r_width  <= bus.OpWidth;
        r_signed <= bus.LoadSigned;
        r_err    <= 1'b0;
      end
      if (r_state == S_DEV_WAIT && bus.PrAck)
        r_rdata <= bus.PrRD;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    bus.Stall    = 1'b0;
    bus.RValid   = 1'b0;
    bus.RData    = '0;
    bus.ExcValid = 1'b0;
    bus.ExcCode  = '0;
    bus.PrReq    = 1'b0;
    bus.PrAddr   = '0;
    bus.PrWE     = 1'b0;
    bus.PrBE     = '0;
    bus.PrWD     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Valid && w_exc_code != 5'd0) begin
          bus.ExcValid = 1'b1;
          bus.ExcCode  = w_exc_code;
        end
        if (w_go) begin
          bus.Stall = !w_dm_wr;
          if (w_dm_rd)
            w_state_nx = S_DM_RD;
          else if (w_dev)
            w_state_nx = S_DEV_WAIT;
        end
      end
      S_DM_RD: begin
        bus.RValid = 1'b1;
        bus.RData  = f_ext(r_ram_q, r_addr[1:0],
                           r_width, r_signed);
        w_state_nx = S_IDLE;
      end
      S_DEV_WAIT: begin
        bus.PrReq  = 1'b1;
        bus.Stall  = 1'b1;
        bus.PrAddr = {r_addr[31:2], 2'b00};
        bus.PrWE   = r_we;
        bus.PrBE   = r_be;
        bus.PrWD   = r_wd;
        if (bus.PrAck || w_tmo)
          w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (r_err) begin
          bus.ExcValid = 1'b1;
          bus.ExcCode  = EXC_DBE;
        end else if (!r_we) begin
          bus.RValid = 1'b1;
          bus.RData  = f_ext(r_rdata, r_addr[1:0],
                             r_width, r_signed);
        end
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus
// hand-written multi-cycle device/RAM sequences.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic        v;
    logic        rd;
    logic        wr;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  ei;
    logic        ir;
    logic        e_ev;
    logic [4:0]  e_code;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input string nm, input logic v, input logic rd,
    input logic wr, input logic [1:0] w, input logic [31:0] a,
    input logic [31:0] d, input logic [4:0] ei, input logic ir,
    input logic ev, input logic [4:0] ec);
    vec_t t;
    t.nm = nm; t.v = v; t.rd = rd; t.wr = wr; t.w = w;
    t.sg = 1'b0; t.a = a; t.d = d; t.ei = ei; t.ir = ir;
    t.e_ev = ev; t.e_code = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rd,
                     input logic wr, input logic [1:0] w,
                     input logic sg, input logic [31:0] a,
                     input logic [31:0] d, input logic [4:0] ei,
                     input logic ir);
    bus.Valid = v; bus.MemRead = rd; bus.MemWrite = wr;
    bus.OpWidth = w; bus.LoadSigned = sg; bus.Addr = a;
    bus.WData = d; bus.ExcCodeIn = ei; bus.IntReq = ir;
  endtask

  task automatic idle();
    drv(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
  endtask

  task automatic dm_load(input string nm, input logic [31:0] a,
                         input logic [1:0] w, input logic sg,
                         input logic [31:0] exp);
    @(posedge clk); #1;
    drv(1, 1, 0, w, sg, a, 32'h0, 5'd0, 0);
    @(negedge clk);
    chk({nm, ":stall"}, bus.Stall, 1);
    chk({nm, ":rv0"}, bus.RValid, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk({nm, ":unstall"}, bus.Stall, 0);
    chk({nm, ":rv1"}, bus.RValid, 1);
    chk({nm, ":rdata"}, bus.RData, exp);
  endtask

  int n;
  int nreq;
  int nstall;

  initial begin
    idle();
    bus.PrAck = 1'b0;
    bus.PrRD  = 32'h0;

    tv.push_back(mk("sw_10", 1,0,1,0, 32'h10, 32'hDEADBEEF, 0,0, 0,0));
    tv.push_back(mk("sw_1ffc", 1,0,1,0, 32'h1FFC, 32'h11223344, 0,0, 0,0));
    tv.push_back(mk("sw_20", 1,0,1,0, 32'h20, 32'h0, 0,0, 0,0));
    tv.push_back(mk("sb_21", 1,0,1,2, 32'h21, 32'hAB, 0,0, 0,0));
    tv.push_back(mk("sh_22", 1,0,1,1, 32'h22, 32'h8001, 0,0, 0,0));
    tv.push_back(mk("sw_30", 1,0,1,0, 32'h30, 32'hCAFEF00D, 0,0, 0,0));
    tv.push_back(mk("sw_30_int", 1,0,1,0, 32'h30, 32'h12345678, 0,1, 0,0));
    tv.push_back(mk("sw_40", 1,0,1,0, 32'h40, 32'hAAAA5555, 0,0, 0,0));
    tv.push_back(mk("sw_40_ei", 1,0,1,0, 32'h40, 32'h0, 10,0, 1,10));
    tv.push_back(mk("sw_6000_ei", 1,0,1,0, 32'h6000, 32'h0, 10,0, 1,10));
    tv.push_back(mk("lw_3", 1,1,0,0, 32'h3, 32'h0, 0,0, 1,4));
    tv.push_back(mk("sb_7f00", 1,0,1,2, 32'h7F00, 32'h0, 0,0, 1,5));
    tv.push_back(mk("sh_21", 1,0,1,1, 32'h21, 32'h0, 0,0, 1,5));
    tv.push_back(mk("lh_7f10", 1,1,0,1, 32'h7F10, 32'h0, 0,0, 1,4));
    tv.push_back(mk("lw_2000", 1,1,0,0, 32'h2000, 32'h0, 0,0, 1,4));
    tv.push_back(mk("sw_7f0c", 1,0,1,0, 32'h7F0C, 32'h0, 0,0, 1,5));
    tv.push_back(mk("sw_6000", 1,0,1,0, 32'h6000, 32'h0, 0,0, 1,5));
    tv.push_back(mk("lw_1_ei3", 1,1,0,0, 32'h1, 32'h0, 3,0, 1,3));
    tv.push_back(mk("inv_lw_3", 0,1,0,0, 32'h3, 32'h0, 0,0, 0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:stall", bus.Stall, 0);
    chk("rst:rvalid", bus.RValid, 0);
    chk("rst:excv", bus.ExcValid, 0);
    chk("rst:prreq", bus.PrReq, 0);
    chk("rst:rdata", bus.RData, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[k]) begin
      @(posedge clk); #1;
      drv(tv[k].v, tv[k].rd, tv[k].wr, tv[k].w, tv[k].sg,
          tv[k].a, tv[k].d, tv[k].ei, tv[k].ir);
      @(negedge clk);
      chk({tv[k].nm, ":excv"}, bus.ExcValid, tv[k].e_ev);
      chk({tv[k].nm, ":code"}, bus.ExcCode, tv[k].e_code);
      chk({tv[k].nm, ":stall"}, bus.Stall, 0);
      chk({tv[k].nm, ":prreq"}, bus.PrReq, 0);
    end
    @(posedge clk); #1;
    idle();

    dm_load("lh_12", 32'h12, 2'b01, 1, 32'hFFFFDEAD);
    dm_load("lbu_10", 32'h10, 2'b10, 0, 32'h000000EF);
    dm_load("lb_13", 32'h13, 2'b10, 1, 32'hFFFFFFDE);
    dm_load("lw_1ffc", 32'h1FFC, 2'b00, 0, 32'h11223344);
    dm_load("lw_20", 32'h20, 2'b00, 0, 32'h8001AB00);
    dm_load("lb_21", 32'h21, 2'b10, 1, 32'hFFFFFFAB);
    dm_load("lbu_21", 32'h21, 2'b10, 0, 32'h000000AB);
    dm_load("lh_22", 32'h22, 2'b01, 1, 32'hFFFF8001);
    dm_load("lhu_22", 32'h22, 2'b01, 0, 32'h00008001);
    dm_load("lw_30", 32'h30, 2'b00, 0, 32'hCAFEF00D);
    dm_load("lw_40", 32'h40, 2'b00, 0, 32'hAAAA5555);

    // device load, PrAck on the 3rd waiting cycle
    @(posedge clk); #1;
    drv(1, 1, 0, 2'b00, 0, 32'h7F14, 32'h0, 5'd0, 0);
    @(negedge clk);
    chk("dev_ld:acc_stall", bus.Stall, 1);
    chk("dev_ld:acc_prreq", bus.PrReq, 0);
    nreq = 0;
    nstall = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      idle();
      bus.PrAck = (c == 2);
      bus.PrRD  = (c == 2) ? 32'h5 : 32'hFFFFFFFF;
      @(negedge clk);
      if (!bus.Stall) break;
      nstall++;
      if (bus.PrReq) nreq++;
      if (c == 0) begin
        chk("dev_ld:praddr", bus.PrAddr, 32'h7F14);
        chk("dev_ld:prbe", bus.PrBE, 4'b1111);
        chk("dev_ld:prwe", bus.PrWE, 0);
      end
    end
    chk("dev_ld:nreq", nreq, 3);
    chk("dev_ld:nstall", nstall, 4);
    chk("dev_ld:rvalid", bus.RValid, 1);
    chk("dev_ld:rdata", bus.RData, 32'h5);
    @(posedge clk); #1;
    bus.PrAck = 1'b0;

    // device store, PrAck already high while still in IDLE
    @(posedge clk); #1;
    drv(1, 0, 1, 2'b00, 0, 32'h7F24, 32'h0BADF00D, 5'd0, 0);
    bus.PrAck = 1'b1;
    @(negedge clk);
    chk("dev_st:acc_stall", bus.Stall, 1);
    chk("dev_st:acc_prreq", bus.PrReq, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("dev_st:prreq", bus.PrReq, 1);
    chk("dev_st:prwe", bus.PrWE, 1);
    chk("dev_st:prwd", bus.PrWD, 32'h0BADF00D);
    chk("dev_st:praddr", bus.PrAddr, 32'h7F24);
    @(posedge clk); #1;
    bus.PrAck = 1'b0;
    @(negedge clk);
    chk("dev_st:done_stall", bus.Stall, 0);
    chk("dev_st:done_rv", bus.RValid, 0);
    chk("dev_st:done_excv", bus.ExcValid, 0);

    // device load that is never acknowledged
    @(posedge clk); #1;
    drv(1, 1, 0, 2'b00, 0, 32'h7F00, 32'h0, 5'd0, 0);
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      if (!bus.Stall) break;
      n++;
`ifndef MEM_ACCESS_TIMEOUT_EN
      if (n == 100) break;
`endif
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    chk("tmo:cycles", n, 15);
    chk("tmo:excv", bus.ExcValid, 1);
    chk("tmo:code", bus.ExcCode, 5'd7);
    chk("tmo:rvalid", bus.RValid, 0);
`else
    chk("hold:cycles", n, 100);
    chk("hold:stall", bus.Stall, 1);
    chk("hold:prreq", bus.PrReq, 1);
    @(posedge clk); #1;
    bus.PrAck = 1'b1;
    bus.PrRD  = 32'h77;
    @(posedge clk); #1;
    bus.PrAck = 1'b0;
    @(negedge clk);
    chk("hold:rvalid", bus.RValid, 1);
    chk("hold:excv", bus.ExcValid, 0);
    chk("hold:rdata", bus.RData, 32'h77);
`endif

    // reset during the 2nd waiting cycle abandons the request
    @(posedge clk); #1;
    drv(1, 1, 0, 2'b00, 0, 32'h7F18, 32'h0, 5'd0, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("rstw:prreq1", bus.PrReq, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw:prreq2", bus.PrReq, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw:prreq0", bus.PrReq, 0);
    chk("rstw:stall0", bus.Stall, 0);
    dm_load("rstw:lw_10", 32'h10, 2'b00, 0, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
